periph_bus: RTL
===============

# periph_bus

Memory-mapped peripheral block on the data side of the pipeline, downstream of the MEM stage. It decodes the EX-stage address, data and read/write strobes that are also presented to data memory, and holds six registers: a reloadable timer with interrupt, a free-running system tick, LEDs, a 7-segment digit register and a synchronised switch input. It returns registered read data aligned with the data-memory read path into MEM/WB. It drives the pipeline interrupt request, replacing the tied-off interrupt input to the hazard/jump logic.

## Interface
- BASE_ADDR, 32'h4000_0000: word-aligned base of the 32-byte peripheral window.
- LED_W, 8: LED register width.
- SW_W, 8: switch input width.
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  reset is synchronous and active-low.
- addr  in  32  byte address from the EX-stage ALU output; bits [1:0] ignored.
- wr_data  in  32  store data from EX.
- mem_read  in  1  load strobe from EX.
- mem_write  in  1  store strobe from EX.
- switches  in  SW_W  asynchronous board switches.
- hit  out  1  combinational; addr lies in [BASE_ADDR, BASE_ADDR+0x1C].
- rd_data  out  32  registered read data; MEM selects it over data memory when hit was set.
- irq  out  1  interrupt request = TCON[1] & TCON[2].
- leds  out  LED_W  LED register.
- digits  out  12  7-segment register: [11:8] anode select, [7:0] segments.

## Operation
- Register map (offset: name, access):
  - 0x00: TH, RW — timer reload value.
  - 0x04: TL, RW — timer count.
  - 0x08: TCON[2:0], RW — [0] enable, [1] irq enable, [2] irq status.
  - 0x0C: LED, RW.
  - 0x10: SWITCH, RO.
  - 0x14: DIGI[11:0], RW.
  - 0x18: SYSTICK, RO.
  - 0x1C: reserved; reads 0.
- Read-only and reserved writes are ignored. Narrow registers read zero-extended. Only the low bits of a write are stored.
- Timer, each cycle with TCON[0]=1:
  - If TL == 32'hFFFF_FFFF: TL <= TH, and TCON[2] <= 1 when TCON[1]=1.
  - Otherwise TL <= TL+1.
- Timer, with TCON[0]=0: TL holds.
- SYSTICK increments every cycle and wraps 32'hFFFF_FFFF -> 0.
- switches pass through a 2-flop synchroniser. SWITCH reads the second flop.
- Write priority:
  - A CPU write to TL or TH in the same cycle as a timer update wins over the count/reload.
  - A CPU write to TCON in the same cycle as an overflow stores wr_data[1:0] and TCON[2] <= wr_data[2] | overflow_set. Hardware set wins, so no interrupt is lost.
- mem_read and mem_write both high: the write is performed and rd_data returns the pre-write value.
- Clearing the interrupt: software writes TCON with bit 2 = 0.

## Timing
- Reset values (reset low at an edge):
  - TH, TL, TCON, SYSTICK, LED, DIGI, rd_data, synchronisers = 0.
  - irq = 0; leds = 0; digits = 0.
- Reset mid-count discards all state on that edge. No write is performed in a reset cycle.
- Read latency is 1 cycle. At the edge where mem_read && hit, rd_data <= the register value before that edge's update.
- When mem_read=0 or hit=0, rd_data <= 0 at the edge.
- A write takes effect at the edge it is presented. A read on the following cycle returns the new value.
- irq rises the cycle after the overflow edge and stays high until TCON[2] or TCON[1] is cleared.
- TH = 32'hFFFF_FFFD with TL = TH gives a period of 3 cycles (FFFD -> FFFE -> FFFF -> reload).
- Switch change to SWITCH-readable value: 2 edges.

## Structure
- Package periph_pkg:
  - Offset constants OFF_TH..OFF_SYSTICK.
  - TCON bit indices TCON_EN, TCON_IE, TCON_IS.
  - Window size constant.
- Sub-module timer_core: TH, TL, TCON, overflow/reload and write-priority logic; exposes irq and register values.
- periph_bus does the decode, the read mux/register, SYSTICK, LED/DIGI and the synchroniser.

## Test plan
- Reset low 2 cycles -> all outputs 0. Read of 0x4000_0018 returns 1 on the first cycle after release, plus cycles elapsed.
- Write TH=FFFF_FFFD, TL=FFFF_FFFD, TCON=3, then idle -> TL reloads every 3 cycles. irq rises 1 cycle after the first overflow. Writing TCON=3 clears it.
- Overflow edge coincides with a TCON write of 3 -> TCON reads 7 and irq stays high.
- Write LED=0x1A5 and DIGI=0xFFF_F123 -> leds=0xA5 and digits=0x123 on the next cycle. Write to 0x4000_0010 -> no change.
- switches=0x3C -> SWITCH reads 0x3C from the third cycle onward. Read of 0x4000_0020 or 0x1000_0000 -> hit=0 and rd_data=0.
- mem_read and mem_write both high to TL (old value 5, write 9) -> rd_data=5; the next read returns 9.

Source files
------------

// File: rtl/periph_pkg.sv
// ---------------------------------------------------------------------------
// periph_pkg
// Shared constants for the memory-mapped peripheral block: register byte
// offsets inside the 32-byte window, TCON bit positions and window size.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

package periph_pkg;

  localparam int unsigned C_WINDOW_BYTES = 32;
  localparam int unsigned C_WINDOW_WORDS = C_WINDOW_BYTES / 4;

  // Byte offsets from BASE_ADDR
  localparam logic [4:0] OFF_TH      = 5'h00;
  localparam logic [4:0] OFF_TL      = 5'h04;
  localparam logic [4:0] OFF_TCON    = 5'h08;
  localparam logic [4:0] OFF_LED     = 5'h0C;
  localparam logic [4:0] OFF_SWITCH  = 5'h10;
  localparam logic [4:0] OFF_DIGI    = 5'h14;
  localparam logic [4:0] OFF_SYSTICK = 5'h18;

  // TCON bit indices
  localparam int unsigned TCON_EN = 0;
  localparam int unsigned TCON_IE = 1;
  localparam int unsigned TCON_IS = 2;

endpackage

`default_nettype wire

// File: rtl/periph_bus_timer_core.sv
// ---------------------------------------------------------------------------
// timer_core
// Reloadable 32-bit timer: TH (reload), TL (count), TCON (enable, irq enable,
// irq status). CPU writes override the hardware count/reload; a hardware
// status set is OR-ed into a coincident TCON write so no interrupt is lost.
// Ports:
//   clk, reset      clock, synchronous active-low reset
//   i_wr_th/tl/tcon one-hot register write strobes (already decoded)
//   i_wdata         store data
//   o_th/o_tl/o_tcon current register values
//   o_irq           TCON.IS & TCON.IE
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module timer_core
  import periph_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_wr_th,
  input  logic        i_wr_tl,
  input  logic        i_wr_tcon,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_th,
  output logic [31:0] o_tl,
  output logic [2:0]  o_tcon,
  output logic        o_irq
);

  logic [31:0] r_th;
  logic [31:0] r_tl;
  logic [2:0]  r_tcon;
  logic        w_ovf;
  logic        w_ovf_set;

  assign w_ovf     = r_tcon[TCON_EN] && (r_tl == 32'hFFFF_FFFF);
  assign w_ovf_set = w_ovf && r_tcon[TCON_IE];

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_th   <= 32'd0;
      r_tl   <= 32'd0;
      r_tcon <= 3'd0;
    end else begin
      if (i_wr_th) begin
        r_th <= i_wdata;
      end

      if (i_wr_tl) begin
        r_tl <= i_wdata;
      end else if (r_tcon[TCON_EN]) begin
        r_tl <= w_ovf ? r_th : r_tl + 32'd1;
      end

      if (i_wr_tcon) begin
        r_tcon <= {i_wdata[TCON_IS] | w_ovf_set, i_wdata[1:0]};
      end else if (w_ovf_set) begin
        r_tcon[TCON_IS] <= 1'b1;
      end
    end
  end

  assign o_th   = r_th;
  assign o_tl   = r_tl;
  assign o_tcon = r_tcon;
  assign o_irq  = r_tcon[TCON_IS] & r_tcon[TCON_IE];

endmodule

`default_nettype wire

// File: rtl/periph_bus.sv
// ---------------------------------------------------------------------------
// periph_bus
// Memory-mapped peripheral window: address decode, registered read mux,
// free-running SYSTICK, LED and 7-segment registers, 2-flop switch
// synchroniser, and the timer (timer_core) that drives the pipeline irq.
// Ports:
//   clk, reset           clock, synchronous active-low reset
//   addr, wr_data        EX-stage byte address and store data
//   mem_read, mem_write  EX-stage load/store strobes
//   switches             asynchronous board switches
//   hit                  combinational window decode
//   rd_data              registered read data (1-cycle latency)
//   irq, leds, digits    interrupt request, LED and 7-segment registers
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module periph_bus
  import periph_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter int unsigned LED_W     = 8,
  parameter int unsigned SW_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      addr,
  input  logic [31:0]      wr_data,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic [SW_W-1:0]  switches,
  output logic             hit,
  output logic [31:0]      rd_data,
  output logic             irq,
  output logic [LED_W-1:0] leds,
  output logic [11:0]      digits
);

  logic [29:0]      w_word_off;
  logic [4:0]       w_off;
  logic             w_wr;
  logic [31:0]      w_rmux;
  logic [31:0]      w_th;
  logic [31:0]      w_tl;
  logic [2:0]       w_tcon;
  logic             w_unused;

  logic [31:0]      r_systick;
  logic [LED_W-1:0] r_led;
  logic [11:0]      r_digi;
  logic [SW_W-1:0]  r_sync1;
  logic [SW_W-1:0]  r_sync2;
  logic [31:0]      r_rd_data;

  // Word distance from the base; subtracting handles any word-aligned base.
  assign w_word_off = addr[31:2] - BASE_ADDR[31:2];
  assign hit        = (w_word_off < 30'(C_WINDOW_WORDS));
  assign w_off      = {w_word_off[2:0], 2'b00};
  assign w_wr       = mem_write && hit;
  assign w_unused   = &{1'b0, addr[1:0]};

  timer_core u_timer (
    .clk      (clk),
    .reset    (reset),
    .i_wr_th  (w_wr && (w_off == OFF_TH)),
    .i_wr_tl  (w_wr && (w_off == OFF_TL)),
    .i_wr_tcon(w_wr && (w_off == OFF_TCON)),
    .i_wdata  (wr_data),
    .o_th     (w_th),
    .o_tl     (w_tl),
    .o_tcon   (w_tcon),
    .o_irq    (irq)
  );

  always_comb begin
    w_rmux = 32'd0;
    case (w_off)
      OFF_TH:      w_rmux = w_th;
      OFF_TL:      w_rmux = w_tl;
      OFF_TCON:    w_rmux = 32'(w_tcon);
      OFF_LED:     w_rmux = 32'(r_led);
      OFF_SWITCH:  w_rmux = 32'(r_sync2);
      OFF_DIGI:    w_rmux = 32'(r_digi);
      OFF_SYSTICK: w_rmux = r_systick;
      default:     w_rmux = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_systick <= 32'd0;
      r_led     <= '0;
      r_digi    <= 12'd0;
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_rd_data <= 32'd0;
    end else begin
      r_systick <= r_systick + 32'd1;
      r_sync1   <= switches;
      r_sync2   <= r_sync1;
      // Mux sees pre-edge register values, so a combined read+write
      // returns the old contents.
      r_rd_data <= (mem_read && hit) ? w_rmux : 32'd0;
      if (w_wr && (w_off == OFF_LED)) begin
        r_led <= wr_data[LED_W-1:0];
      end
      if (w_wr && (w_off == OFF_DIGI)) begin
        r_digi <= wr_data[11:0];
      end
    end
  end

  assign rd_data = r_rd_data;
  assign leds    = r_led;
  assign digits  = r_digi;

endmodule

`default_nettype wire
